// File: rtl/aw_arbiter_if.sv
// AW-channel bundle between NUM_M requesting masters, the arbiter, the downstream
// AW FIFO write port and the W-mux route output. Masters are packed, master 0 in the LSBs.
interface aw_arbiter_if #(
    parameter int NUM_M      = 4,
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 4,
    parameter int SIZE_WIDTH = 3
);
    localparam int IDX_W = $clog2(NUM_M);

    logic [NUM_M-1:0]            AWVALID_m;
    logic [NUM_M-1:0]            AWREADY_m;
    logic [NUM_M*ID_WIDTH-1:0]   AWID_m;
    logic [NUM_M*ADDR_WIDTH-1:0] AWADDR_m;
    logic [NUM_M*LEN_WIDTH-1:0]  AWLEN_m;
    logic [NUM_M*SIZE_WIDTH-1:0] AWSIZE_m;
    logic [NUM_M*2-1:0]          AWBURST_m;
    logic                        fifo_full;
    logic                        fifo_push;
    logic [IDX_W+ID_WIDTH-1:0]   out_AWID;
    logic [ADDR_WIDTH-1:0]       out_AWADDR;
    logic [LEN_WIDTH-1:0]        out_AWLEN;
    logic [SIZE_WIDTH-1:0]       out_AWSIZE;
    logic [1:0]                  out_AWBURST;
    logic                        w_route_valid;
    logic [IDX_W-1:0]            w_route_idx;
    logic                        w_burst_done;

    // Requesting side: masters, FIFO status and the W mux.
    modport master (
        output AWVALID_m, AWID_m, AWADDR_m, AWLEN_m, AWSIZE_m, AWBURST_m,
        output fifo_full, w_burst_done,
        input  AWREADY_m, fifo_push, out_AWID, out_AWADDR, out_AWLEN,
        input  out_AWSIZE, out_AWBURST, w_route_valid, w_route_idx
    );

    modport slave (
        input  AWVALID_m, AWID_m, AWADDR_m, AWLEN_m, AWSIZE_m, AWBURST_m,
        input  fifo_full, w_burst_done,
        output AWREADY_m, fifo_push, out_AWID, out_AWADDR, out_AWLEN,
        output out_AWSIZE, out_AWBURST, w_route_valid, w_route_idx
    );
endinterface

// File: rtl/aw_arbiter.sv
// Round-robin AW arbiter: one request per two cycles into the AW FIFO, winner index
// queued for the W mux. Define AW_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module aw_arbiter #(
    parameter int NUM_M       = 4,
    parameter int ID_WIDTH    = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int LEN_WIDTH   = 4,
    parameter int SIZE_WIDTH  = 3,
    parameter int ROUTE_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    aw_arbiter_if.slave  bus
);
    localparam int IDX_W = $clog2(NUM_M);
    localparam int PTR_W = $clog2(ROUTE_DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(ROUTE_DEPTH);

    typedef enum logic {ARB, HOLD} state_t;

    state_t           state_reg;
    logic [IDX_W-1:0] grant_reg;
`ifndef AW_ARB_FIXED_PRIO_EN
    logic [IDX_W-1:0] rr_ptr_reg;
`endif

    logic [IDX_W-1:0] route_mem [ROUTE_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;

    logic [IDX_W-1:0] winner;
    logic             winner_found;
    logic             push;
    logic             pop;

    // Scan from highest offset down so the lowest offset from the start point wins.
    always_comb begin : search
        int               j;
        logic [IDX_W-1:0] cand;
        winner       = '0;
        winner_found = 1'b0;
        j            = 0;
        cand         = '0;
        for (int i = NUM_M - 1; i >= 0; i--) begin
`ifdef AW_ARB_FIXED_PRIO_EN
            j = i;
`else
            j = int'(rr_ptr_reg) + i;
            if (j >= NUM_M) j = j - NUM_M;
`endif
            cand = IDX_W'(j);
            if (bus.AWVALID_m[cand]) begin
                winner       = cand;
                winner_found = 1'b1;
            end
        end
    end

    assign push = (state_reg == HOLD) && !bus.fifo_full;
    assign pop  = bus.w_burst_done && (count_reg != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ARB;
            grant_reg  <= '0;
`ifndef AW_ARB_FIXED_PRIO_EN
            rr_ptr_reg <= '0;
`endif
        end else begin
            case (state_reg)
                ARB: begin
                    // Uses the registered count: a pop in this cycle only frees room next cycle.
                    if (winner_found && (count_reg != FULL_COUNT)) begin
                        grant_reg <= winner;
                        state_reg <= HOLD;
                    end
                end
                HOLD: begin
                    if (!bus.fifo_full) begin
                        state_reg  <= ARB;
`ifndef AW_ARB_FIXED_PRIO_EN
                        rr_ptr_reg <= (grant_reg == IDX_W'(NUM_M - 1)) ? '0 : grant_reg + 1'b1;
`endif
                    end
                end
                default: state_reg <= ARB;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            route_mem  <= '{default: '0};
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                route_mem[wr_ptr_reg] <= grant_reg;
                wr_ptr_reg            <= wr_ptr_reg + 1'b1;
            end
            if (pop) rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (push && !pop)      count_reg <= count_reg + 1'b1;
            else if (!push && pop) count_reg <= count_reg - 1'b1;
        end
    end

    logic [ID_WIDTH-1:0]   id_arr   [NUM_M];
    logic [ADDR_WIDTH-1:0] addr_arr [NUM_M];
    logic [LEN_WIDTH-1:0]  len_arr  [NUM_M];
    logic [SIZE_WIDTH-1:0] size_arr [NUM_M];
    logic [1:0]            burst_arr[NUM_M];

    for (genvar gi = 0; gi < NUM_M; gi++) begin : g_master
        assign id_arr[gi]    = bus.AWID_m[gi*ID_WIDTH +: ID_WIDTH];
        assign addr_arr[gi]  = bus.AWADDR_m[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign len_arr[gi]   = bus.AWLEN_m[gi*LEN_WIDTH +: LEN_WIDTH];
        assign size_arr[gi]  = bus.AWSIZE_m[gi*SIZE_WIDTH +: SIZE_WIDTH];
        assign burst_arr[gi] = bus.AWBURST_m[gi*2 +: 2];
        assign bus.AWREADY_m[gi] = push && (grant_reg == IDX_W'(gi));
    end

    assign bus.fifo_push     = push;
    assign bus.out_AWID      = {grant_reg, id_arr[grant_reg]};
    assign bus.out_AWADDR    = addr_arr[grant_reg];
    assign bus.out_AWLEN     = len_arr[grant_reg];
    assign bus.out_AWSIZE    = size_arr[grant_reg];
    assign bus.out_AWBURST   = burst_arr[grant_reg];
    assign bus.w_route_valid = (count_reg != '0);
    assign bus.w_route_idx   = route_mem[rd_ptr_reg];
endmodule

// File: tb/tb_aw_arbiter.sv
// Directed bench for aw_arbiter: queue-based reference model checked every cycle,
// plus literal expectations for the listed scenarios.
module tb_aw_arbiter;
    localparam int NUM_M       = 4;
    localparam int ID_WIDTH    = 4;
    localparam int ADDR_WIDTH  = 32;
    localparam int LEN_WIDTH   = 4;
    localparam int SIZE_WIDTH  = 3;
    localparam int ROUTE_DEPTH = 4;
    localparam int IDX_W       = $clog2(NUM_M);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    aw_arbiter_if #(.NUM_M(NUM_M), .ID_WIDTH(ID_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
                    .LEN_WIDTH(LEN_WIDTH), .SIZE_WIDTH(SIZE_WIDTH)) bus ();

    aw_arbiter #(.NUM_M(NUM_M), .ID_WIDTH(ID_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
                 .LEN_WIDTH(LEN_WIDTH), .SIZE_WIDTH(SIZE_WIDTH),
                 .ROUTE_DEPTH(ROUTE_DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [ID_WIDTH-1:0]   id_tab   [NUM_M] = '{4'h1, 4'h5, 4'hA, 4'hC};
    logic [ADDR_WIDTH-1:0] addr_tab [NUM_M] = '{32'h0000_0100, 32'h2000_0000, 32'h0000_1000, 32'hDEAD_BEE0};
    logic [LEN_WIDTH-1:0]  len_tab  [NUM_M] = '{4'd3, 4'd4, 4'd5, 4'd6};
    logic [SIZE_WIDTH-1:0] size_tab [NUM_M] = '{3'd0, 3'd1, 3'd2, 3'd3};
    logic [1:0]            burst_tab[NUM_M] = '{2'd1, 2'd0, 2'd1, 2'd2};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end else begin
            $display("ok   %s = %0h (cycle %0d)", name, act, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: pending grant plus a queue of winner indices.
    bit m_hold  = 1'b0;
    int m_grant = 0;
    int m_rr    = 0;
    int mq[$];

    initial begin : model
        int pre;
        int idx;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_hold = 1'b0; m_grant = 0; m_rr = 0; mq.delete();
            end else begin
                pre = mq.size();
                if (bus.w_burst_done && pre > 0) void'(mq.pop_front());
                if (m_hold) begin
                    if (!bus.fifo_full) begin
                        mq.push_back(m_grant);
                        m_rr   = (m_grant + 1) % NUM_M;
                        m_hold = 1'b0;
                    end
                end else if (pre < ROUTE_DEPTH) begin
                    for (int k = 0; k < NUM_M; k++) begin
                        idx = (m_rr + k) % NUM_M;
                        if (bus.AWVALID_m[idx]) begin
                            m_grant = idx; m_hold = 1'b1;
                            break;
                        end
                    end
                end
`ifdef AW_ARB_FIXED_PRIO_EN
                m_rr = 0;
`endif
            end
        end
    end

    // Per-cycle compare against the model, on the falling edge.
    logic             e_push;
    logic [NUM_M-1:0] e_ready;
    logic [IDX_W-1:0] e_idx;
    initial begin : compare
        forever begin
            @(negedge clk);
            if (!rst) begin
                e_push  = m_hold && !bus.fifo_full;
                e_ready = '0;
                if (e_push) e_ready[m_grant] = 1'b1;
                e_idx = m_grant[IDX_W-1:0];
                chk("m_push", bus.fifo_push, e_push);
                chk("m_ready", bus.AWREADY_m, e_ready);
                chk("m_route_valid", bus.w_route_valid, mq.size() > 0);
                if (mq.size() > 0) chk("m_route_idx", bus.w_route_idx, mq[0]);
                if (m_hold) begin
                    chk("m_awid", bus.out_AWID, {e_idx, bus.AWID_m[m_grant*ID_WIDTH +: ID_WIDTH]});
                    chk("m_addr", bus.out_AWADDR, bus.AWADDR_m[m_grant*ADDR_WIDTH +: ADDR_WIDTH]);
                    chk("m_len", bus.out_AWLEN, bus.AWLEN_m[m_grant*LEN_WIDTH +: LEN_WIDTH]);
                    chk("m_size", bus.out_AWSIZE, bus.AWSIZE_m[m_grant*SIZE_WIDTH +: SIZE_WIDTH]);
                    chk("m_burst", bus.out_AWBURST, bus.AWBURST_m[m_grant*2 +: 2]);
                end
            end
        end
    end

    // Masters drop AWVALID after their handshake.
    logic [NUM_M-1:0] drop;
    initial begin : auto_drop
        forever begin
            @(negedge clk);
            drop = bus.AWREADY_m;
            @(posedge clk);
            #1;
            bus.AWVALID_m = bus.AWVALID_m & ~drop;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_push(input int limit, output int idx, output int at);
        bit found = 1'b0;
        idx = -1; at = -1;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            if (bus.fifo_push) begin
                found = 1'b1;
                idx = int'(bus.out_AWID[IDX_W+ID_WIDTH-1:ID_WIDTH]);
                at  = cyc;
                break;
            end
        end
        chk("push_seen", found, 1'b1);
    endtask

    task automatic pulse_done();
        tick();
        bus.w_burst_done = 1'b1;
        tick();
        bus.w_burst_done = 1'b0;
    endtask

    int pidx, pat, prev;
    logic [3:0] seen;

    initial begin : stim
        bus.AWVALID_m = '0; bus.fifo_full = 1'b0; bus.w_burst_done = 1'b0;
        for (int i = 0; i < NUM_M; i++) begin
            bus.AWID_m[i*ID_WIDTH +: ID_WIDTH]       = id_tab[i];
            bus.AWADDR_m[i*ADDR_WIDTH +: ADDR_WIDTH] = addr_tab[i];
            bus.AWLEN_m[i*LEN_WIDTH +: LEN_WIDTH]    = len_tab[i];
            bus.AWSIZE_m[i*SIZE_WIDTH +: SIZE_WIDTH] = size_tab[i];
            bus.AWBURST_m[i*2 +: 2]                  = burst_tab[i];
        end

        // All four request through reset; grants go 0,1,2,3 two cycles apart.
        bus.AWVALID_m = 4'b1111;
        repeat (3) tick();
        chk("rst_ready", bus.AWREADY_m, 4'b0000);
        chk("rst_push", bus.fifo_push, 1'b0);
        chk("rst_route_valid", bus.w_route_valid, 1'b0);
        chk("rst_route_idx", bus.w_route_idx, 2'd0);
        rst = 1'b0;
        prev = 0;
        for (int n = 0; n < 4; n++) begin
            wait_push(8, pidx, pat);
            chk("order", pidx, n);
            if (n > 0) chk("spacing", pat - prev, 2);
            prev = pat;
        end
        tick();
        chk("q_head0", bus.w_route_idx, 2'd0);
        chk("q_valid", bus.w_route_valid, 1'b1);

        // Queue full: fifth request waits until a pop has taken effect.
        bus.AWVALID_m[1] = 1'b1;
        seen = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            seen[k] = bus.fifo_push;
        end
        chk("full_no_push", seen, 4'b0000);
        tick();
        bus.w_burst_done = 1'b1;
        tick();
        bus.w_burst_done = 1'b0;
        @(negedge clk);
        chk("pop_head1", bus.w_route_idx, 2'd1);
        chk("pop_same_cycle_no_push", bus.fifo_push, 1'b0);
        @(negedge clk);
        chk("fifth_push", bus.fifo_push, 1'b1);
        chk("fifth_awid", bus.out_AWID, 6'h15);

        // Drain the queue.
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (!bus.w_route_valid) break;
            pulse_done();
        end
        @(negedge clk);
        chk("drained", bus.w_route_valid, 1'b0);

        // Lone master 2: one-cycle AWREADY on the cycle after its request is seen.
        tick();
        bus.AWVALID_m[2] = 1'b1;
        seen = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            seen[k] = (bus.AWREADY_m == 4'b0100);
            if (bus.fifo_push) begin
                chk("m2_awid", bus.out_AWID, 6'h2A);
                chk("m2_addr", bus.out_AWADDR, 32'h0000_1000);
            end
        end
        chk("m2_ready_once", seen, 4'b0010);

        // FIFO full for five HOLD cycles, push on the first non-full cycle.
        tick();
        bus.fifo_full = 1'b1;
        bus.AWVALID_m[3] = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("full_hold_push", bus.fifo_push, 1'b0);
            chk("full_hold_id", bus.out_AWID, 6'h3C);
            chk("full_hold_addr", bus.out_AWADDR, 32'hDEAD_BEE0);
        end
        tick();
        bus.fifo_full = 1'b0;
        @(negedge clk);
        chk("full_release_push", bus.fifo_push, 1'b1);
        chk("full_release_ready", bus.AWREADY_m, 4'b1000);

        // Queue holds 2,3; push master 0 while popping.
        tick();
        bus.AWVALID_m[0] = 1'b1;
        tick();
        bus.w_burst_done = 1'b1;
        @(negedge clk);
        chk("sim_push", bus.fifo_push, 1'b1);
        tick();
        bus.w_burst_done = 1'b0;
        @(negedge clk);
        chk("sim_head3", bus.w_route_idx, 2'd3);
        pulse_done();
        @(negedge clk);
        chk("sim_head0", bus.w_route_idx, 2'd0);
        chk("sim_valid", bus.w_route_valid, 1'b1);

        // Reset while pushing; arbitration restarts from master 0.
        tick();
        bus.AWVALID_m[2] = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        chk("hold_push_before_rst", bus.fifo_push, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_mid_ready", bus.AWREADY_m, 4'b0000);
        chk("rst_mid_push", bus.fifo_push, 1'b0);
        chk("rst_mid_route_valid", bus.w_route_valid, 1'b0);
        bus.AWVALID_m = 4'b1001;
        repeat (2) tick();
        rst = 1'b0;
        wait_push(8, pidx, pat);
        chk("restart_first", pidx, 0);
        wait_push(8, pidx, pat);
        chk("restart_second", pidx, 3);
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end
endmodule
